// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared types and constants for the ROM loader.
//   region_e       - ROM storage region selector (MAIN, SND, GFX, DEC)
//   state_e        - loader FSM states
//   *_BASE/*_LIMIT - region map on the 17-bit ioctl byte address
//   ROM_SET_INDEX  - the only ioctl_index that is accepted
//   HOLD_CYCLES    - cpu_reset_n hold time after the download ends
//   EXPECTED_BYTES - size of a complete ROM set
`timescale 1ns/1ps
package rom_loader_pkg;

    typedef enum logic [1:0] {
        REGION_MAIN = 2'd0,
        REGION_SND  = 2'd1,
        REGION_GFX  = 2'd2,
        REGION_DEC  = 2'd3
    } region_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_FLUSH,
        ST_HOLD,
        ST_DONE
    } state_e;

    localparam logic [16:0] MAIN_BASE  = 17'h00000;
    localparam logic [16:0] MAIN_LIMIT = 17'h0FFFF;
    localparam logic [16:0] SND_BASE   = 17'h10000;
    localparam logic [16:0] SND_LIMIT  = 17'h17FFF;
    localparam logic [16:0] GFX_BASE   = 17'h18000;
    localparam logic [16:0] GFX_LIMIT  = 17'h1DFFF;
    localparam logic [16:0] DEC_BASE   = 17'h1E000;
    localparam logic [16:0] DEC_LIMIT  = 17'h1FFFF;

    localparam logic [7:0]  ROM_SET_INDEX  = 8'h00;
    localparam int          HOLD_CYCLES    = 16;
    localparam logic [17:0] EXPECTED_BYTES = 18'h20000;

endpackage

// File: rtl/rom_loader_if.sv
// rom_loader_if: HPS ioctl download port plus the ROM storage write port.
//   master modport - the loader: consumes ioctl_* and mem_ack,
//                    drives ioctl_wait and mem_req/sel/addr/data
//   slave modport  - the HPS/storage side, opposite directions
`timescale 1ns/1ps
interface rom_loader_if;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [16:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        mem_req;
    logic [1:0]  mem_sel;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_ack;

    modport master (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ack,
        output ioctl_wait, mem_req, mem_sel, mem_addr, mem_data
    );

    modport slave (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ack,
        input  ioctl_wait, mem_req, mem_sel, mem_addr, mem_data
    );
endinterface

// File: rtl/rom_region_decode.sv
// rom_region_decode: combinational ROM-set address decoder, shared by the
// loader write path and the storage-side read mux.
//   addr_i   - 17-bit byte address within the ROM set
//   sel_o    - region the address falls into
//   offset_o - region-relative byte address (truncated to 16 bits)
`timescale 1ns/1ps
module rom_region_decode
    import rom_loader_pkg::*;
(
    input  logic [16:0] addr_i,
    output region_e     sel_o,
    output logic [15:0] offset_o
);

    logic [16:0] base;

    // The map tiles the whole 17-bit space, so the last region is the fallthrough.
    always_comb begin
        if (addr_i <= MAIN_LIMIT) begin
            sel_o = REGION_MAIN;
            base  = MAIN_BASE;
        end else if (addr_i <= SND_LIMIT) begin
            sel_o = REGION_SND;
            base  = SND_BASE;
        end else if (addr_i <= GFX_LIMIT) begin
            sel_o = REGION_GFX;
            base  = GFX_BASE;
        end else begin
            sel_o = REGION_DEC;
            base  = DEC_BASE;
        end
        offset_o = 16'(addr_i - base);
    end

endmodule

// File: rtl/rom_loader.sv
// rom_loader: receives the arcade ROM set from the HPS ioctl port, writes it
// byte by byte into ROM storage and holds the CPU in reset until done.
//   clk_sys     - system clock, all logic on the rising edge
//   reset_n     - asynchronous active-low reset
//   bus         - rom_loader_if.master (ioctl download + storage write port)
//   cpu_reset_n - active-low CPU hold, released only in DONE
//   load_done   - complete error-free 0x20000-byte load has finished
//   load_err    - sticky: a byte arrived while a write was still pending
//   checksum    - XOR of all accepted bytes
`timescale 1ns/1ps
module rom_loader
    import rom_loader_pkg::*;
(
    input  logic         clk_sys,
    input  logic         reset_n,
    rom_loader_if.master bus,
    output logic         cpu_reset_n,
    output logic         load_done,
    output logic         load_err,
    output logic [7:0]   checksum
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_e      state_q, state_d;
    logic        req_q, req_d;
    region_e     sel_q, sel_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  cks_q, cks_d;
    logic [17:0] cnt_q, cnt_d;
    logic [3:0]  hold_q, hold_d;
    logic        err_q, err_d;
    logic        done_q, done_d;
    logic        cpu_rst_n_q, cpu_rst_n_d;
    logic        dl_q, dl_d;

    logic        dl_qual;
    logic        dl_rise;
    region_e     dec_sel;
    logic [15:0] dec_off;

    rom_region_decode u_decode (
        .addr_i   (bus.ioctl_addr),
        .sel_o    (dec_sel),
        .offset_o (dec_off)
    );

    assign dl_qual = bus.ioctl_download && (bus.ioctl_index == ROM_SET_INDEX);
    assign dl_rise = dl_qual && !dl_q;

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        data_d      = data_q;
        cks_d       = cks_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        err_d       = err_q;
        done_d      = done_q;
        cpu_rst_n_d = cpu_rst_n_q;
        dl_d        = dl_qual;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (dl_rise) begin
                    state_d     = ST_LOAD;
                    cks_d       = 8'h00;
                    cnt_d       = '0;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    cpu_rst_n_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (!bus.ioctl_download) begin
                    state_d = ST_HOLD;
                    hold_d  = '0;
                end else if (bus.ioctl_wr) begin
                    state_d = ST_WRITE;
                    req_d   = 1'b1;
                    sel_d   = dec_sel;
                    addr_d  = dec_off;
                    data_d  = bus.ioctl_dout;
                end
            end
            ST_WRITE, ST_FLUSH: begin
                // A byte while a write is pending is an HPS overrun: dropped.
                if (bus.ioctl_wr) begin
                    err_d = 1'b1;
                end
                if (bus.mem_ack) begin
                    req_d = 1'b0;
                    cks_d = cks_q ^ data_q;
                    cnt_d = (cnt_q == EXPECTED_BYTES) ? cnt_q : cnt_q + 18'd1;
                    if ((state_q == ST_FLUSH) || !bus.ioctl_download) begin
                        state_d = ST_HOLD;
                        hold_d  = '0;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else if ((state_q == ST_WRITE) && !bus.ioctl_download) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d     = ST_DONE;
                    cpu_rst_n_d = 1'b1;
                    done_d      = !err_q && (cnt_q == EXPECTED_BYTES);
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            req_q       <= 1'b0;
            sel_q       <= REGION_MAIN;
            addr_q      <= '0;
            data_q      <= '0;
            cks_q       <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            // Edge detector starts "high" so a download still asserted at
            // reset release is not mistaken for a fresh download edge.
            dl_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cks_q       <= cks_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            err_q       <= err_d;
            done_q      <= done_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            dl_q        <= dl_d;
        end
    end

    // The HPS stall is exactly the window in which a write is outstanding.
    assign bus.ioctl_wait = req_q;
    assign bus.mem_req    = req_q;
    assign bus.mem_sel    = sel_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_data   = data_q;
    assign cpu_reset_n    = cpu_rst_n_q;
    assign load_done      = done_q;
    assign load_err       = err_q;
    assign checksum       = cks_q;

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: randomized, scoreboard-checked bench for rom_loader.
`timescale 1ns/1ps
module tb_rom_loader;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic       cpu_reset_n;
    logic       load_done;
    logic       load_err;
    logic [7:0] checksum;

    rom_loader_if bus ();

    rom_loader dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .bus         (bus),
        .cpu_reset_n (cpu_reset_n),
        .load_done   (load_done),
        .load_err    (load_err),
        .checksum    (checksum)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic [1:0]  sel;
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    int   checks = 0;
    int   errors = 0;
    wr_t  exp_q[$];
    int   ack_delay = 0;
    bit   req_seen = 0;
    bit   wait_seen = 0;

    // Reference model of the load, kept at the level of "bytes accepted".
    logic [7:0] m_cks = 8'h00;
    int         m_cnt = 0;
    bit         m_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    function automatic wr_t model_map(input int a, input logic [7:0] d);
        wr_t w;
        if (a < 'h10000) begin
            w.sel = 2'd0; w.addr = 16'(a);
        end else if (a < 'h18000) begin
            w.sel = 2'd1; w.addr = 16'(a - 'h10000);
        end else if (a < 'h1E000) begin
            w.sel = 2'd2; w.addr = 16'(a - 'h18000);
        end else begin
            w.sel = 2'd3; w.addr = 16'(a - 'h1E000);
        end
        w.data = d;
        return w;
    endfunction

    function automatic void model_clear();
        m_cks = 8'h00;
        m_cnt = 0;
        m_err = 0;
    endfunction

    function automatic void expect_byte(input int a, input logic [7:0] d);
        exp_q.push_back(model_map(a, d));
        m_cks = m_cks ^ d;
        if (m_cnt < 131072) m_cnt++;
    endfunction

    function automatic logic model_done();
        return (!m_err && m_cnt == 131072);
    endfunction

    // Storage model: acks a pending request after ack_delay extra cycles.
    initial begin
        int w;
        w = 0;
        bus.mem_ack = 1'b0;
        forever begin
            @(posedge clk_sys);
            #2;
            bus.mem_ack = 1'b0;
            if (bus.mem_req === 1'b1) begin
                if (w >= ack_delay) begin
                    bus.mem_ack = 1'b1;
                    w = 0;
                end else begin
                    w++;
                end
            end else begin
                w = 0;
            end
        end
    end

    // Monitor: every cycle a request is outstanding it must match the head
    // of the scoreboard; the entry retires on the accepting ack.
    always @(negedge clk_sys) begin
        if (bus.ioctl_wait === 1'b1) wait_seen = 1;
        if (bus.mem_req === 1'b1) begin
            req_seen = 1;
            if (exp_q.size() == 0) begin
                check("unexpected_mem_req", 32'(bus.mem_req), 32'd0);
            end else begin
                check("mem_sel",  32'(bus.mem_sel),  32'(exp_q[0].sel));
                check("mem_addr", 32'(bus.mem_addr), 32'(exp_q[0].addr));
                check("mem_data", 32'(bus.mem_data), 32'(exp_q[0].data));
                if (bus.mem_ack === 1'b1) void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic raw_wr(input logic [16:0] a, input logic [7:0] d);
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        bus.ioctl_wr   = 1'b1;
        tick();
        bus.ioctl_wr   = 1'b0;
    endtask

    task automatic wait_low(output int n);
        n = 0;
        while (bus.ioctl_wait === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("ack_timeout", 32'(bus.ioctl_wait), 32'd0);
    endtask

    task automatic hps_write(input logic [16:0] a, input logic [7:0] d, input bit drop_dl, output int wc);
        expect_byte(int'(a), d);
        raw_wr(a, d);
        if (drop_dl) bus.ioctl_download = 1'b0;
        wait_low(wc);
    endtask

    task automatic start_dl(input logic [7:0] idx);
        bus.ioctl_index    = idx;
        bus.ioctl_download = 1'b1;
        if (idx == 8'h00) model_clear();
        tick();
    endtask

    task automatic end_dl();
        bus.ioctl_download = 1'b0;
        tick();
    endtask

    task automatic measure_hold(input string name);
        int n;
        n = 0;
        check({name, "_cpu_reset_n_held"}, 32'(cpu_reset_n), 32'd0);
        while (cpu_reset_n !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        check({name, "_hold_cycles"}, 32'(n), 32'd16);
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc;
        int bad;
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'h00;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;

        // Reset values
        repeat (3) tick();
        check("rst_mem_req",     32'(bus.mem_req),    32'd0);
        check("rst_ioctl_wait",  32'(bus.ioctl_wait), 32'd0);
        check("rst_cpu_reset_n", 32'(cpu_reset_n),    32'd0);
        check("rst_load_done",   32'(load_done),      32'd0);
        check("rst_load_err",    32'(load_err),       32'd0);
        check("rst_checksum",    32'(checksum),       32'd0);
        check("rst_mem_sel",     32'(bus.mem_sel),    32'd0);
        check("rst_mem_addr",    32'(bus.mem_addr),   32'd0);
        check("rst_mem_data",    32'(bus.mem_data),   32'd0);
        reset_n = 1'b1;
        tick();
        tick();
        $display("txn reset cpu_reset_n=%0b checksum=%02h", cpu_reset_n, checksum);

        // Single DEC write, ack three cycles late
        start_dl(8'h00);
        ack_delay = 3;
        hps_write(17'h1E123, 8'hA5, 1'b0, wc);
        check("t035_wait_cycles", 32'(wc), 32'd4);
        check("t035_checksum", 32'(checksum), 32'h0A5);
        check("t035_sb_drained", 32'(exp_q.size()), 32'd0);
        end_dl();
        measure_hold("t035");
        check("t035_load_done", 32'(load_done), 32'(model_done()));
        check("t035_load_err",  32'(load_err),  32'(m_err));
        $display("txn t035 addr=1e123 data=a5 wait=%0d checksum=%02h", wc, checksum);

        // Full ROM set, random data, immediate ack, then repeated addresses
        start_dl(8'h00);
        ack_delay = 0;
        bad = 0;
        for (int a = 0; a < 131072; a++) begin
            hps_write(17'(a), 8'($urandom), 1'b0, wc);
            if (wc != 1) bad++;
        end
        for (int i = 0; i < 4; i++) begin
            hps_write(17'($urandom_range(0, 131071)), 8'($urandom), 1'b0, wc);
            if (wc != 1) bad++;
        end
        check("t036_ack_latency", 32'(bad), 32'd0);
        check("t036_sb_drained", 32'(exp_q.size()), 32'd0);
        end_dl();
        measure_hold("t036");
        check("t036_load_done", 32'(load_done), 32'(model_done()));
        check("t036_load_err",  32'(load_err),  32'(m_err));
        check("t036_checksum",  32'(checksum),  32'(m_cks));
        $display("txn t036 bytes=%0d checksum=%02h done=%0b", m_cnt, checksum, load_done);

        // Overrun: second byte while the first is still pending
        start_dl(8'h00);
        ack_delay = 4;
        expect_byte('h00400, 8'h3C);
        raw_wr(17'h00400, 8'h3C);
        raw_wr(17'h00401, 8'hC3);
        m_err = 1;
        check("t037_load_err_now", 32'(load_err), 32'(m_err));
        wait_low(wc);
        check("t037_sb_drained", 32'(exp_q.size()), 32'd0);
        check("t037_checksum", 32'(checksum), 32'(m_cks));
        end_dl();
        measure_hold("t037");
        check("t037_load_done", 32'(load_done), 32'(model_done()));
        check("t037_load_err",  32'(load_err),  32'd1);
        $display("txn t037 overrun err=%0b checksum=%02h", load_err, checksum);

        // Download falls while a write waits five cycles for ack
        start_dl(8'h00);
        ack_delay = 5;
        hps_write(17'h18010, 8'h5A, 1'b1, wc);
        check("t038_wait_cycles", 32'(wc), 32'd6);
        measure_hold("t038");
        check("t038_sb_drained", 32'(exp_q.size()), 32'd0);
        check("t038_checksum",  32'(checksum),  32'h05A);
        check("t038_load_done", 32'(load_done), 32'(model_done()));
        check("t038_load_err",  32'(load_err),  32'(m_err));
        $display("txn t038 flush checksum=%02h cpu_reset_n=%0b", checksum, cpu_reset_n);

        // Foreign index download is ignored entirely
        req_seen  = 0;
        wait_seen = 0;
        ack_delay = 0;
        start_dl(8'h01);
        for (int i = 0; i < 100; i++) begin
            raw_wr(17'($urandom_range(0, 131071)), 8'($urandom));
            tick();
        end
        end_dl();
        tick();
        bus.ioctl_index = 8'h00;
        check("t039_req_seen",    32'(req_seen),    32'd0);
        check("t039_wait_seen",   32'(wait_seen),   32'd0);
        check("t039_cpu_reset_n", 32'(cpu_reset_n), 32'd1);
        check("t039_load_done",   32'(load_done),   32'(model_done()));
        check("t039_load_err",    32'(load_err),    32'(m_err));
        check("t039_checksum",    32'(checksum),    32'(m_cks));
        $display("txn t039 index1 bytes=100 req_seen=%0b", req_seen);

        // Reset pulsed in the middle of a write
        start_dl(8'h00);
        ack_delay = 0;
        hps_write(17'h0ABCD, 8'h77, 1'b0, wc);
        ack_delay = 20;
        exp_q.push_back(model_map('h1F000, 8'h99));
        raw_wr(17'h1F000, 8'h99);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("t040_mem_req",     32'(bus.mem_req),    32'd0);
        check("t040_ioctl_wait",  32'(bus.ioctl_wait), 32'd0);
        check("t040_cpu_reset_n", 32'(cpu_reset_n),    32'd0);
        check("t040_load_done",   32'(load_done),      32'd0);
        check("t040_load_err",    32'(load_err),       32'd0);
        check("t040_checksum",    32'(checksum),       32'd0);
        check("t040_mem_sel",     32'(bus.mem_sel),    32'd0);
        check("t040_mem_addr",    32'(bus.mem_addr),   32'd0);
        check("t040_mem_data",    32'(bus.mem_data),   32'd0);
        exp_q.delete();
        model_clear();
        tick();
        reset_n  = 1'b1;
        req_seen = 0;
        tick();
        raw_wr(17'h00010, 8'h11);
        tick();
        tick();
        check("t040_idle_no_req",    32'(req_seen),    32'd0);
        check("t040_idle_cpu_reset", 32'(cpu_reset_n), 32'd0);
        bus.ioctl_download = 1'b0;
        tick();
        ack_delay = 0;
        start_dl(8'h00);
        hps_write(17'h10005, 8'h42, 1'b0, wc);
        check("t040_reload_checksum", 32'(checksum), 32'(m_cks));
        end_dl();
        measure_hold("t040");
        check("t040_reload_done", 32'(load_done), 32'(model_done()));
        $display("txn t040 reset_mid_write reload_checksum=%02h", checksum);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
